// File: rtl/rv_exec_unit.sv
// Execution slice: 32x32 register file plus ALU-control decoder and ALU.
// Latency: reads, decode and ALU are combinational; register writes land on the rising clk edge.
// Backpressure: none; every write with we=1 is taken at the edge unless reset is high.
// Optional macro RV_EXEC_RF_BYPASS_EN forwards data_in to a read port that matches the write address.
module rv_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  w,
  input  logic [31:0] data_in,
  input  logic        we,
  output logic [31:0] data_out1,
  output logic [31:0] data_out2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [3:0]  fmt,
  input  logic [31:0] ALU_srcA,
  input  logic [31:0] ALU_srcB,
  output logic [3:0]  ALU_ctr,
  output logic [31:0] ALU_resp,
  output logic        zero
);

  // ALU operation encoding as seen on ALU_ctr.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSA = 4'd10
  } alu_op_e;

  // Instruction format codes carried on fmt.
  typedef enum logic [3:0] {
    FMT_R  = 4'd0,
    FMT_I  = 4'd1,
    FMT_IL = 4'd2,
    FMT_IE = 4'd3,
    FMT_S  = 4'd4,
    FMT_B  = 4'd5,
    FMT_J  = 4'd6,
    FMT_JI = 4'd7,
    FMT_U  = 4'd8,
    FMT_UP = 4'd9
  } fmt_e;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [31:0] r_regs [0:31];
  logic        w_wr_en;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  // Writes to x0 are dropped here so entry 0 only ever holds its reset value.
  assign w_wr_en = we && (w != 5'd0);

  // Storage: async clear of every entry, then edge-triggered write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_wr_en) begin
      r_regs[w] <= data_in;
    end
  end

  // Read ports: x0 is hard zero, reset forces zero, optional write forwarding.
  always_comb begin
    w_rd1 = (rs1 == 5'd0) ? 32'd0 : r_regs[rs1];
    w_rd2 = (rs2 == 5'd0) ? 32'd0 : r_regs[rs2];
`ifdef RV_EXEC_RF_BYPASS_EN
    if (w_wr_en && (rs1 == w)) w_rd1 = data_in;
    if (w_wr_en && (rs2 == w)) w_rd2 = data_in;
`endif
    if (reset) begin
      w_rd1 = 32'd0;
      w_rd2 = 32'd0;
    end
  end

  assign data_out1 = w_rd1;
  assign data_out2 = w_rd2;

  // ---------------------------------------------------------------------------
  // ALU control decoder
  // ---------------------------------------------------------------------------
  alu_op_e w_op;
  alu_op_e w_rop;
  logic    w_alt;

  // Only funct7[5] distinguishes operations; the remaining bits are don't-care.
  assign w_alt = funct7[5];
  logic w_unused_funct7;
  assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Register-register decode; the immediate form reuses it with overrides.
  always_comb begin
    w_rop = ALU_ADD;
    case (funct3)
      3'd0: w_rop = w_alt ? ALU_SUB : ALU_ADD;
      3'd1: w_rop = ALU_SLL;
      3'd2: w_rop = ALU_SLT;
      3'd3: w_rop = ALU_SLTU;
      3'd4: w_rop = ALU_XOR;
      3'd5: w_rop = w_alt ? ALU_SRA : ALU_SRL;
      3'd6: w_rop = ALU_OR;
      3'd7: w_rop = ALU_AND;
      default: w_rop = ALU_ADD;
    endcase
  end

  // Format-level decode: immediates never subtract, U passes A, all else adds.
  always_comb begin
    w_op = ALU_ADD;
    case (fmt)
      FMT_R:   w_op = w_rop;
      FMT_I:   w_op = (funct3 == 3'd0) ? ALU_ADD : w_rop;
      FMT_U:   w_op = ALU_PASSA;
      FMT_IL, FMT_IE, FMT_S, FMT_B,
      FMT_J, FMT_JI, FMT_UP: w_op = ALU_ADD;
      default: w_op = ALU_ADD;
    endcase
  end

  assign ALU_ctr = w_op;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [4:0]  w_shamt;
  logic [31:0] w_res;

  assign w_shamt = ALU_srcB[4:0];

  // Result select driven from the ALU_ctr encoding; unused codes add.
  always_comb begin
    w_res = ALU_srcA + ALU_srcB;
    case (ALU_ctr)
      4'd0:  w_res = ALU_srcA + ALU_srcB;
      4'd1:  w_res = ALU_srcA - ALU_srcB;
      4'd2:  w_res = ALU_srcA << w_shamt;
      4'd3:  w_res = {31'd0, ($signed(ALU_srcA) < $signed(ALU_srcB))};
      4'd4:  w_res = {31'd0, (ALU_srcA < ALU_srcB)};
      4'd5:  w_res = ALU_srcA ^ ALU_srcB;
      4'd6:  w_res = ALU_srcA >> w_shamt;
      4'd7:  w_res = $unsigned($signed(ALU_srcA) >>> w_shamt);
      4'd8:  w_res = ALU_srcA | ALU_srcB;
      4'd9:  w_res = ALU_srcA & ALU_srcB;
      4'd10: w_res = ALU_srcA;
      default: w_res = ALU_srcA + ALU_srcB;
    endcase
  end

  assign ALU_resp = w_res;
  assign zero     = (w_res == 32'd0);

endmodule

// File: tb/tb_rv_exec_unit.sv
// Directed bench for rv_exec_unit: register file, reset behaviour and ALU decode.
// Inputs change on the falling edge; outputs are checked away from the rising edge.
// Expected values are hand-computed constants.
module tb_rv_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, w;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] data_out1, data_out2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [3:0]  fmt;
  logic [31:0] ALU_srcA, ALU_srcB;
  logic [3:0]  ALU_ctr;
  logic [31:0] ALU_resp;
  logic        zero;

  int n_checks = 0;
  int n_errors = 0;

  rv_exec_unit dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .w(w),
    .data_in(data_in), .we(we), .data_out1(data_out1), .data_out2(data_out2),
    .funct3(funct3), .funct7(funct7), .fmt(fmt),
    .ALU_srcA(ALU_srcA), .ALU_srcB(ALU_srcB),
    .ALU_ctr(ALU_ctr), .ALU_resp(ALU_resp), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one ALU vector, let it settle, check decode, result and zero flag.
  task automatic alu(input string tag, input logic [3:0] f, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] ectr, input logic [31:0] eres);
    fmt = f; funct3 = f3; funct7 = f7; ALU_srcA = a; ALU_srcB = b;
    #1;
    chk({tag, "_ctr"},  {28'd0, ALU_ctr}, {28'd0, ectr});
    chk({tag, "_resp"}, ALU_resp, eres);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (eres == 32'd0)});
  endtask

  initial begin
    reset = 1'b1; rs1 = 5'd5; rs2 = 5'd9; w = 5'd0; data_in = 32'd0; we = 1'b0;
    funct3 = 3'd0; funct7 = 7'd0; fmt = 4'd0; ALU_srcA = 32'd0; ALU_srcB = 32'd0;
    #2;
    chk("reset_rd1", data_out1, 32'd0);
    chk("reset_rd2", data_out2, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_x5", data_out1, 32'd0);

    // Write x5 and watch the same-cycle read, then the committed value.
    @(negedge clk);
    we = 1'b1; w = 5'd5; data_in = 32'h12345678; rs1 = 5'd5; rs2 = 5'd0;
    #1;
`ifdef RV_EXEC_RF_BYPASS_EN
    chk("rdw_x5_bypass", data_out1, 32'h12345678);
`else
    chk("rdw_x5_old", data_out1, 32'd0);
`endif
    @(posedge clk); #1;
    we = 1'b0; #1;
    chk("x5_rd1", data_out1, 32'h12345678);
    chk("x0_rd2", data_out2, 32'd0);

    // Port-2 read during a write to x7.
    @(negedge clk);
    we = 1'b1; w = 5'd7; data_in = 32'hCAFEF00D; rs1 = 5'd5; rs2 = 5'd7;
    #1;
`ifdef RV_EXEC_RF_BYPASS_EN
    chk("rdw_x7_bypass", data_out2, 32'hCAFEF00D);
`else
    chk("rdw_x7_old", data_out2, 32'd0);
`endif
    chk("rdw_x5_other_port", data_out1, 32'h12345678);
    @(posedge clk); #1;
    we = 1'b0; #1;
    chk("x7_rd2", data_out2, 32'hCAFEF00D);

    // Write to x0 must be ignored, including any forwarding.
    @(negedge clk);
    we = 1'b1; w = 5'd0; data_in = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    chk("x0_during_write", data_out1, 32'd0);
    @(posedge clk); #1;
    we = 1'b0; #1;
    chk("x0_after_write", data_out1, 32'd0);

    // Load x3 and x9, then reset asynchronously mid-cycle.
    @(negedge clk);
    we = 1'b1; w = 5'd3; data_in = 32'd7;
    @(negedge clk);
    w = 5'd9; data_in = 32'hA5A5A5A5;
    @(negedge clk);
    we = 1'b0; rs1 = 5'd3; rs2 = 5'd9; #1;
    chk("x3_loaded", data_out1, 32'd7);
    chk("x9_loaded", data_out2, 32'hA5A5A5A5);
    #1;
    reset = 1'b1;
    #1;
    chk("x3_async_reset", data_out1, 32'd0);
    chk("x9_async_reset", data_out2, 32'd0);
    // ALU is stateless and ignores reset.
    alu("alu_in_reset", 4'd0, 3'd0, 7'h00, 32'd40, 32'd2, 4'd0, 32'd42);

    // Write attempted across an edge while reset is held: reset wins.
    we = 1'b1; w = 5'd3; data_in = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("write_in_reset_rd", data_out1, 32'd0);
    @(negedge clk);
    we = 1'b0; reset = 1'b0; #1;
    chk("x3_after_reset", data_out1, 32'd0);
    chk("x9_after_reset", data_out2, 32'd0);
    rs1 = 5'd5; #1;
    chk("x5_after_reset", data_out1, 32'd0);

    // ALU decode and datapath vectors.
    alu("r_sub",        4'd0, 3'd0, 7'h20, 32'd5,        32'd7,        4'd1,  32'hFFFFFFFE);
    alu("i_sra",        4'd1, 3'd5, 7'h20, 32'h80000000, 32'd4,        4'd7,  32'hF8000000);
    alu("i_srl",        4'd1, 3'd5, 7'h00, 32'h80000000, 32'd4,        4'd6,  32'h08000000);
    alu("u_passa",      4'd8, 3'd0, 7'h00, 32'hABCDE000, 32'd12,       4'd10, 32'hABCDE000);
    alu("r_sltu",       4'd0, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1,        4'd4,  32'd0);
    alu("r_slt",        4'd0, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        4'd3,  32'd1);
    alu("i_add_f7",     4'd1, 3'd0, 7'h20, 32'd5,        32'd7,        4'd0,  32'd12);
    alu("r_sll",        4'd0, 3'd1, 7'h00, 32'd1,        32'h21,       4'd2,  32'd2);
    alu("r_xor",        4'd0, 3'd4, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 4'd5,  32'h0FF00FF0);
    alu("r_or",         4'd0, 3'd6, 7'h00, 32'hF0F0F0F0, 32'h0F0F0000, 4'd8,  32'hFFFFF0F0);
    alu("r_and",        4'd0, 3'd7, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 4'd9,  32'hF000F000);
    alu("s_add_wrap",   4'd4, 3'd7, 7'h20, 32'hFFFFFFFF, 32'd1,        4'd0,  32'd0);
    alu("r_sra",        4'd0, 3'd5, 7'h20, 32'h80000000, 32'd4,        4'd7,  32'hF8000000);
    alu("i_slt_f7",     4'd1, 3'd2, 7'h20, 32'd5,        32'd7,        4'd3,  32'd1);
    alu("fmt15_add",    4'd15,3'd7, 7'h20, 32'd1,        32'd2,        4'd0,  32'd3);
    alu("r_add_ovf",    4'd0, 3'd0, 7'h00, 32'h7FFFFFFF, 32'd1,        4'd0,  32'h80000000);
    alu("r_sub_wrap",   4'd0, 3'd0, 7'h20, 32'd0,        32'd1,        4'd1,  32'hFFFFFFFF);
    alu("ji_add",       4'd7, 3'd5, 7'h20, 32'd10,       32'd4,        4'd0,  32'd14);
    alu("b_add",        4'd5, 3'd1, 7'h00, 32'd3,        32'd4,        4'd0,  32'd7);
    alu("up_add",       4'd9, 3'd4, 7'h00, 32'h1000,     32'h20,       4'd0,  32'h1020);
    alu("r_srl_shamt",  4'd0, 3'd5, 7'h00, 32'h80000000, 32'h3F,       4'd6,  32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rv_exec_unit.md
RV_EXEC_UNIT -- requirements
Module: rv_exec_unit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and the register count at 32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rs1  input  5  register-file read address, port 1.
REQ-005 rs2  input  5  register-file read address, port 2.
REQ-006 w  input  5  register-file write address.
REQ-007 data_in  input  32  register-file write data.
REQ-008 we  input  1  register-file write enable.
REQ-009 data_out1  output  32  read data for rs1.
REQ-010 data_out2  output  32  read data for rs2.
REQ-011 funct3  input  3  instruction bits [14:12].
REQ-012 funct7  input  7  instruction bits [31:25].
REQ-013 fmt  input  4  format code: 0 R, 1 I, 2 IL (load), 3 IE (env), 4 S, 5 B, 6 J, 7 JI (jalr), 8 U (lui), 9 UP (auipc).
REQ-014 ALU_srcA  input  32  ALU operand A.
REQ-015 ALU_srcB  input  32  ALU operand B.
REQ-016 ALU_ctr  output  4  decoded ALU operation.
REQ-017 ALU_resp  output  32  ALU result.
REQ-018 zero  output  1  high when ALU_resp == 0.

Function
REQ-019 Register file: 32 x 32-bit; reads are combinational from rs1/rs2; the write occurs at the rising clk edge when we=1.
REQ-020 Register x0 SHALL always read 0; writes with w=0 are ignored.
REQ-021 ALU_ctr encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSA; values 11-15 are unused and SHALL produce ADD.
REQ-022 fmt R decode by funct3: 0 ADD, or SUB when funct7[5]=1; 1 SLL; 2 SLT; 3 SLTU; 4 XOR; 5 SRL, or SRA when funct7[5]=1; 6 OR; 7 AND.
REQ-023 fmt I decodes as R, except that funct3=0 is always ADD; funct7[5] selects SRA only when funct3=5.
REQ-024 fmt IL, IE, S, B, J, JI, UP and codes 10-15 SHALL decode to ADD; fmt U SHALL decode to PASSA.
REQ-025 The ALU SHALL be purely combinational; ALU_resp SHALL be valid in the same cycle as its operands, with no clk dependence.
REQ-026 The shift amount SHALL be ALU_srcB[4:0]; SRA SHALL be arithmetic on signed A; SLT SHALL be a signed compare and SLTU an unsigned compare, each giving 1 or 0.
REQ-027 ADD and SUB SHALL wrap modulo 2^32 and no overflow flag SHALL be produced.
REQ-028 PASSA SHALL output ALU_srcA unchanged and ignore ALU_srcB.

Reset
REQ-029 Asserting reset SHALL clear registers x1-x31 to 0 immediately, independent of clk.
REQ-030 While reset=1, writes SHALL be blocked and data_out1/data_out2 SHALL read 0.
REQ-031 The ALU and decoder SHALL hold no state and SHALL be unaffected by reset.
REQ-032 If reset is asserted in the same cycle as a write, reset SHALL win and the register SHALL read 0.

Configuration
REQ-033 Macro RV_EXEC_RF_BYPASS_EN selects the read-during-write behaviour of the register file.
REQ-034 With RV_EXEC_RF_BYPASS_EN defined: when we=1, w!=0 and rs1 or rs2 equals w, the matching read port SHALL return data_in combinationally in the same cycle.
REQ-035 Without RV_EXEC_RF_BYPASS_EN: such a read SHALL return the old contents until after the clk edge.

Verification
REQ-036 Write x5=0x12345678 at a clk edge, then rs1=5 and rs2=0 -> data_out1=0x12345678, data_out2=0.
REQ-037 Write x0=0xFFFFFFFF, then rs1=0 -> data_out1=0.
REQ-038 fmt=0, funct3=0, funct7=0x20, A=5, B=7 -> ALU_ctr=1, ALU_resp=0xFFFFFFFE, zero=0.
REQ-039 fmt=1, funct3=5, funct7=0x20, A=0x80000000, B=4 -> ALU_resp=0xF8000000; the same stimulus with funct7=0 -> 0x08000000.
REQ-040 fmt=8, A=0xABCDE000, B=12 -> ALU_resp=0xABCDE000; fmt=0, funct3=3, A=0xFFFFFFFF, B=1 -> ALU_resp=0 and zero=1.
REQ-041 Load x3=7, assert reset mid-cycle -> data_out1 for rs1=3 reads 0 before the next clk edge; repeat the write-then-read test with and without RV_EXEC_RF_BYPASS_EN.
